// File: rtl/cnt_share_arb.sv
// rtl/cnt_share_arb.sv - round-robin arbiter and burst sequencer for one shared up-counter
// Optional macro CNT_SHARE_ARB_STAT_EN adds the saturating grant_cnt output.
module cnt_share_arb #(
    parameter int NREQ  = 4,
    parameter int CW    = 4,
    parameter int BURST = 8,
    parameter int OW    = 2
) (
    input  logic            clk_100M,
    input  logic            rst_,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [OW-1:0]   owner,
    output logic [CW-1:0]   cnt,
    output logic            busy,
    output logic            done,
    output logic            abort
`ifdef CNT_SHARE_ARB_STAT_EN
    ,
    output logic [7:0]      grant_cnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [OW-1:0] IDX_MAX  = OW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [OW-1:0]   last, last_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            busy_nxt, done_nxt, abort_nxt;
    logic            pick_hit;
    logic [OW-1:0]   pick_idx, scan_idx;
    logic            own_req, at_last;

    assign own_req = req[owner];
    assign at_last = (cnt == CNT_LAST);

    // Scan starts one past the previous winner so every waiter is served in turn.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        scan_idx = last;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (scan_idx == IDX_MAX) ? '0 : scan_idx + OW'(1);
            if (!pick_hit && req[scan_idx]) begin
                pick_hit = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_100M or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            last  <= IDX_MAX;
            grant <= '0;
            owner <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            abort <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit) state_nxt = RUN;
            RUN:     if (at_last || !own_req) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion is judged on the registered count first, so a late drop still ends in done.
    always_comb begin
        grant_nxt = grant;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    grant_nxt = NREQ'(1) << pick_idx;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (at_last) begin
                    done_nxt  = 1'b1;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end else if (!own_req) begin
                    abort_nxt = 1'b1;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef CNT_SHARE_ARB_STAT_EN
    always_ff @(posedge clk_100M or negedge rst_) begin
        if (!rst_) begin
            grant_cnt <= '0;
        end else if (state == IDLE && pick_hit && grant_cnt != 8'hFF) begin
            grant_cnt <= grant_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnt_share_arb.sv
// tb/tb_cnt_share_arb.sv - scoreboard bench for cnt_share_arb (BURST=8 and BURST=1 instances)
module tb_cnt_share_arb;
    localparam int NREQ = 4;

    logic       clk_100M = 1'b0;
    logic       rst_;
    logic [3:0] req;
    logic [3:0] grant0, grant1, cnt0, cnt1;
    logic [1:0] owner0, owner1;
    logic       busy0, busy1, done0, done1, abort0, abort1;
`ifdef CNT_SHARE_ARB_STAT_EN
    logic [7:0] gcnt0, gcnt1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_100M = ~clk_100M;

    cnt_share_arb #(.NREQ(4), .CW(4), .BURST(8), .OW(2)) u0 (
        .clk_100M(clk_100M), .rst_(rst_), .req(req), .grant(grant0), .owner(owner0),
        .cnt(cnt0), .busy(busy0), .done(done0), .abort(abort0)
`ifdef CNT_SHARE_ARB_STAT_EN
        , .grant_cnt(gcnt0)
`endif
    );

    cnt_share_arb #(.NREQ(4), .CW(4), .BURST(1), .OW(2)) u1 (
        .clk_100M(clk_100M), .rst_(rst_), .req(req), .grant(grant1), .owner(owner1),
        .cnt(cnt1), .busy(busy1), .done(done1), .abort(abort1)
`ifdef CNT_SHARE_ARB_STAT_EN
        , .grant_cnt(gcnt1)
`endif
    );

    // Reference: who holds the counter, how many counts it has had, and the turnaround left.
    typedef struct {
        bit held;
        int cool;
        int own;
        int last;
        int c;
        bit done;
        bit abort;
        int gcnt;
    } mdl_t;

    mdl_t m0, m1, e0, e1;
    mdl_t q0[$];
    mdl_t q1[$];

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.held = 0; m.cool = 0; m.own = 0; m.last = NREQ - 1;
        m.c = 0; m.done = 0; m.abort = 0; m.gcnt = 0;
        return m;
    endfunction

    function automatic bit bit_of(input logic [3:0] r, input int j);
        return ((r >> j) & 4'b0001) != 4'b0000;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r, input int burst);
        m.done = 0;
        m.abort = 0;
        if (m.held) begin
            if (m.c == burst - 1) begin
                m.done = 1; m.held = 0; m.cool = 1;
            end else if (!bit_of(r, m.own)) begin
                m.abort = 1; m.held = 0; m.cool = 1;
            end else begin
                m.c = m.c + 1;
            end
        end else if (m.cool > 0) begin
            m.cool = m.cool - 1;
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (bit_of(r, (m.last + k) % NREQ)) begin
                    m.own = (m.last + k) % NREQ;
                    break;
                end
            end
            m.last = m.own;
            m.c = 0;
            m.held = 1;
            if (m.gcnt < 255) m.gcnt = m.gcnt + 1;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t e, input int g, input int o,
                       input int c, input int b, input int d, input int a);
        chk({tag, ".grant"}, g, e.held ? (1 << e.own) : 0);
        chk({tag, ".owner"}, o, e.own);
        chk({tag, ".cnt"},   c, e.c);
        chk({tag, ".busy"},  b, int'(e.held));
        chk({tag, ".done"},  d, int'(e.done));
        chk({tag, ".abort"}, a, int'(e.abort));
    endtask

    // Monitor: pops one expectation per cycle, samples on the falling edge.
    initial begin
        forever begin
            @(negedge clk_100M);
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                cmp("b8", e0, int'(grant0), int'(owner0), int'(cnt0), int'(busy0), int'(done0), int'(abort0));
                cmp("b1", e1, int'(grant1), int'(owner1), int'(cnt1), int'(busy1), int'(done1), int'(abort1));
`ifdef CNT_SHARE_ARB_STAT_EN
                chk("b8.grant_cnt", int'(gcnt0), e0.gcnt);
                chk("b1.grant_cnt", int'(gcnt1), e1.gcnt);
`endif
            end
        end
    end

    task automatic tick(input logic [3:0] nreq);
        @(posedge clk_100M);
        #1;
        if (!rst_) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m0 = mdl_step(m0, req, 8);
            m1 = mdl_step(m1, req, 1);
        end
        q0.push_back(m0);
        q1.push_back(m1);
        req = nreq;
    endtask

    task automatic run_until(input int own, input int c);
        int n = 0;
        while (!(m0.held && m0.own == own && m0.c == c) && n < 100) begin
            tick(req);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL wait_owner%0d_cnt%0d actual=timeout required=reached", own, c);
        end
    endtask

    task automatic inject_reset();
        @(posedge clk_100M);
        #1;
        rst_ = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    initial begin
        int hold;
        rst_ = 1'b0;
        req  = 4'b0000;
        m0 = mdl_reset();
        m1 = mdl_reset();
        tick(4'b0000);
        tick(4'b0000);
        rst_ = 1'b1;

        tick(4'b0001);
        repeat (25) tick(4'b0001);

        repeat (45) tick(4'b1111);

        req = 4'b0100;
        run_until(2, 3);
        req = 4'b1011;
        repeat (14) tick(4'b1011);

        req = 4'b0010;
        run_until(1, 5);
        inject_reset();
        tick(4'b0010);
        tick(4'b0010);
        rst_ = 1'b1;
        repeat (12) tick(4'b0010);

        hold = 0;
        repeat (400) begin
            if (hold == 0) begin
                hold = int'($urandom_range(1, 12));
                tick(4'($urandom_range(0, 15)));
            end else begin
                tick(req);
            end
            hold--;
        end

        repeat (920) tick(4'b0001);

        for (int n = 0; n < 5 && q0.size() > 0; n++) @(negedge clk_100M);
        @(negedge clk_100M);
        if (q0.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
